// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// It owns bubble injection, data-memory wait handling with timeout, and
// interrupt entry, which drains the pipeline before the handler vector loads.
// Ports:
//   CLK, Reset_n           clock (rising edge), async active-low reset
//   ID_rs/ID_rt/ID_Uses*   source registers read by the instruction in ID
//   ID_Jump                jump resolved in ID
//   EX_MemRd/EX_rt         load in EX and its destination register
//   EX_BrTaken             branch in EX resolved taken
//   MEM_Req/MEM_Ready      data-memory access in MEM / access completes
//   IRQ/IRQ_En             level interrupt request / global enable
//   CntClr                 synchronous clear of StallCount
//   PC_Write..BusErr       Mealy-decoded pipeline controls, all 0 in reset
//   StallCount             registered saturating count of PC_Write=0 cycles
module pipe_hazard_ctrl #(
  parameter int unsigned MAX_WAIT     = 16,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_Jump,
  input  logic             EX_MemRd,
  input  logic [4:0]       EX_rt,
  input  logic             EX_BrTaken,
  input  logic             MEM_Req,
  input  logic             MEM_Ready,
  input  logic             IRQ,
  input  logic             IRQ_En,
  input  logic             CntClr,
  output logic             PC_Write,
  output logic             IF_Protect,
  output logic             IF_Flush,
  output logic             ID_Flush,
  output logic             MEM_Stall,
  output logic             IRQ_Take,
  output logic             BusErr,
  output logic [CNT_W-1:0] StallCount
);

  localparam int unsigned WAIT_W  = 8;
  localparam int unsigned DRAIN_W = 3;

  typedef enum logic [1:0] {RUN, MEM_WAIT, IRQ_DRAIN} state_t;

  state_t              state, state_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic [DRAIN_W-1:0]  drain_cnt, drain_cnt_nxt;
  logic                timeout, mem_stall, load_use;
  logic                pc_w, if_prot, if_fl, id_fl, mem_st, irq_tk, bus_er;

  // State and counter registers
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // Next-state and prioritised control decode
  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    drain_cnt_nxt = drain_cnt;
    pc_w          = 1'b1;
    if_prot       = 1'b0;
    if_fl         = 1'b0;
    id_fl         = 1'b0;
    mem_st        = 1'b0;
    irq_tk        = 1'b0;
    bus_er        = 1'b0;

    timeout   = (state == MEM_WAIT) && (wait_cnt == WAIT_W'(MAX_WAIT - 1));
    mem_stall = MEM_Req && !MEM_Ready && !timeout;
    load_use  = EX_MemRd && (EX_rt != 5'd0) &&
                ((ID_UsesRs && (ID_rs == EX_rt)) || (ID_UsesRt && (ID_rt == EX_rt)));

    if (mem_stall) begin
      mem_st  = 1'b1;
      pc_w    = 1'b0;
      if_prot = 1'b1;
      case (state)
        RUN: begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = '0;
        end
        MEM_WAIT: wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        default: ;  // drain progress frozen while memory stalls
      endcase
    end else if (state == IRQ_DRAIN) begin
      // Fetch stays flushed; drained instructions complete on their own
      if_fl = 1'b1;
      if (drain_cnt == DRAIN_W'(DRAIN_CYCLES)) begin
        irq_tk    = 1'b1;
        state_nxt = RUN;
      end else begin
        pc_w          = 1'b0;
        drain_cnt_nxt = drain_cnt + DRAIN_W'(1);
      end
    end else begin
      // Leaving MEM_WAIT releases the stall this same cycle
      if (state == MEM_WAIT) begin
        state_nxt = RUN;
        bus_er    = timeout && MEM_Req && !MEM_Ready;
      end
      if (EX_BrTaken) begin
        if_fl = 1'b1;
        id_fl = 1'b1;
      end else if (load_use) begin
        pc_w    = 1'b0;
        if_prot = 1'b1;
        id_fl   = 1'b1;
      end else if (ID_Jump) begin
        if_fl = 1'b1;
      end else if (IRQ && IRQ_En && (state == RUN)) begin
        // Entry cycle is already the first drain cycle
        state_nxt     = IRQ_DRAIN;
        drain_cnt_nxt = DRAIN_W'(1);
        pc_w          = 1'b0;
        if_fl         = 1'b1;
      end
    end
  end

  // Controls are forced low while reset is held
  assign PC_Write   = Reset_n & pc_w;
  assign IF_Protect = Reset_n & if_prot;
  assign IF_Flush   = Reset_n & if_fl;
  assign ID_Flush   = Reset_n & id_fl;
  assign MEM_Stall  = Reset_n & mem_st;
  assign IRQ_Take   = Reset_n & irq_tk;
  assign BusErr     = Reset_n & bus_er;

  // Saturating stall-cycle counter, clear wins over increment
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      StallCount <= '0;
    end else if (CntClr) begin
      StallCount <= '0;
    end else if (!pc_w && (StallCount != {CNT_W{1'b1}})) begin
      StallCount <= StallCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. The 7-bit output vector is
// {PC_Write, IF_Protect, IF_Flush, ID_Flush, MEM_Stall, IRQ_Take, BusErr}.
module tb_pipe_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        Reset_n;
  logic [4:0]  ID_rs, ID_rt, EX_rt;
  logic        ID_UsesRs, ID_UsesRt, ID_Jump, EX_MemRd, EX_BrTaken;
  logic        MEM_Req, MEM_Ready, IRQ, IRQ_En, CntClr;
  logic        PC_Write, IF_Protect, IF_Flush, ID_Flush, MEM_Stall, IRQ_Take, BusErr;
  logic [15:0] StallCount;
  logic [6:0]  outs;

  int n_chk  = 0;
  int n_pass = 0;

  pipe_hazard_ctrl #(.MAX_WAIT(16), .DRAIN_CYCLES(3), .CNT_W(16)) dut (
    .CLK(CLK), .Reset_n(Reset_n),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_Jump(ID_Jump), .EX_MemRd(EX_MemRd), .EX_rt(EX_rt), .EX_BrTaken(EX_BrTaken),
    .MEM_Req(MEM_Req), .MEM_Ready(MEM_Ready), .IRQ(IRQ), .IRQ_En(IRQ_En),
    .CntClr(CntClr),
    .PC_Write(PC_Write), .IF_Protect(IF_Protect), .IF_Flush(IF_Flush),
    .ID_Flush(ID_Flush), .MEM_Stall(MEM_Stall), .IRQ_Take(IRQ_Take),
    .BusErr(BusErr), .StallCount(StallCount)
  );

  assign outs = {PC_Write, IF_Protect, IF_Flush, ID_Flush, MEM_Stall, IRQ_Take, BusErr};

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Let inputs settle, then compare the control vector
  task automatic chk_outs(input string tag, input logic [6:0] exp);
    #1;
    check(tag, 32'(outs), 32'(exp));
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ID_rs = 5'd0; ID_rt = 5'd0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0; ID_Jump = 1'b0;
    EX_MemRd = 1'b0; EX_rt = 5'd0; EX_BrTaken = 1'b0;
    MEM_Req = 1'b0; MEM_Ready = 1'b0; IRQ = 1'b0; IRQ_En = 1'b0; CntClr = 1'b0;
  endtask

  task automatic load_use_rs();
    EX_MemRd = 1'b1; EX_rt = 5'd5;
    ID_rs = 5'd5; ID_UsesRs = 1'b1; ID_rt = 5'd7; ID_UsesRt = 1'b1;
  endtask

  initial begin
    Reset_n = 1'b0;
    idle();
    #2;
    check("reset_outs", 32'(outs), 32'd0);
    check("reset_cnt", 32'(StallCount), 32'd0);
    cyc(); cyc();
    Reset_n = 1'b1;
    chk_outs("idle", 7'b1000000);

    // lw $5 in EX, add $6,$5,$7 in ID: single bubble
    cyc(); load_use_rs();
    chk_outs("lu_rs", 7'b0101000);
    cyc(); idle();
    chk_outs("lu_after", 7'b1000000);
    check("cnt_lu", 32'(StallCount), 32'd1);

    cyc(); load_use_rs(); EX_rt = 5'd0; ID_rs = 5'd0;
    chk_outs("lu_r0", 7'b1000000);
    cyc(); load_use_rs(); ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
    chk_outs("lu_nouse", 7'b1000000);
    cyc(); load_use_rs(); ID_rs = 5'd9; ID_rt = 5'd5;
    chk_outs("lu_rt", 7'b0101000);

    // Taken branch outranks load-use
    cyc(); load_use_rs(); EX_BrTaken = 1'b1;
    chk_outs("br_lu", 7'b1011000);
    cyc(); idle(); ID_Jump = 1'b1;
    chk_outs("jump", 7'b1010000);
    check("cnt_2", 32'(StallCount), 32'd2);

    // Four wait cycles, branch held in EX is deferred until release
    cyc(); idle(); MEM_Req = 1'b1; EX_BrTaken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_outs("mem4_stall", 7'b0100100);
      cyc();
    end
    MEM_Ready = 1'b1;
    chk_outs("mem4_release", 7'b1011000);
    cyc(); idle();
    chk_outs("mem4_after", 7'b1000000);
    check("cnt_6", 32'(StallCount), 32'd6);

    // Memory never ready: 16 stall cycles, then BusErr with stall released
    MEM_Req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk_outs("memto_stall", 7'b0100100);
      cyc();
    end
    chk_outs("memto_buserr", 7'b1000001);
    cyc(); idle();
    chk_outs("memto_after", 7'b1000000);
    check("cnt_22", 32'(StallCount), 32'd22);

    // IRQ entry: three drain cycles then IRQ_Take; IRQ level ignored meanwhile
    IRQ = 1'b1; IRQ_En = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_outs("irq_drain", 7'b0010000);
      cyc();
    end
    chk_outs("irq_take", 7'b1010010);
    cyc(); idle();
    chk_outs("irq_after", 7'b1000000);
    check("cnt_25", 32'(StallCount), 32'd25);
    IRQ = 1'b1;
    chk_outs("irq_masked", 7'b1000000);

    // Two-cycle memory stall inside the drain slips IRQ_Take by two
    cyc(); IRQ_En = 1'b1;
    chk_outs("irqm_entry", 7'b0010000);
    cyc(); idle(); MEM_Req = 1'b1;
    chk_outs("irqm_stall1", 7'b0100100);
    cyc();
    chk_outs("irqm_stall2", 7'b0100100);
    cyc(); MEM_Ready = 1'b1;
    chk_outs("irqm_drain2", 7'b0010000);
    cyc(); idle(); ID_Jump = 1'b1; EX_BrTaken = 1'b1;
    chk_outs("irqm_drain3", 7'b0010000);
    cyc(); idle();
    chk_outs("irqm_take", 7'b1010010);
    cyc();
    chk_outs("irqm_after", 7'b1000000);
    check("cnt_30", 32'(StallCount), 32'd30);

    // Clear has priority over a concurrent increment
    load_use_rs(); CntClr = 1'b1;
    chk_outs("clr_lu", 7'b0101000);
    cyc(); idle();
    check("cnt_clr", 32'(StallCount), 32'd0);
    cyc();
    check("cnt_clr_hold", 32'(StallCount), 32'd0);

    // Reset in the middle of a memory wait returns to RUN with a fresh budget
    MEM_Req = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    Reset_n = 1'b0;
    chk_outs("rst_mid_outs", 7'b0000000);
    check("rst_mid_cnt", 32'(StallCount), 32'd0);
    cyc();
    Reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk_outs("rst_mem_stall", 7'b0100100);
      cyc();
    end
    chk_outs("rst_mem_buserr", 7'b1000001);
    cyc(); idle();
    chk_outs("rst_mem_after", 7'b1000000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
